pipelined_alu: RTL and testbench
================================

Name: pipelined_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU in the EX stage.
- Adds a valid/ready handshake on input and output, and a real Zero flag.
- MUL is iterative shift-add, processing MUL_STEP multiplier bits per cycle; all other ops complete in one cycle.
- Sits between ID/EX and EX/MEM; the hazard unit stalls on in_ready_o low.

Parameters:
- WIDTH, 32, operand and result width in bits; power of two, at least 8.
- MUL_STEP, 1, multiplier bits consumed per MUL cycle; must divide WIDTH.
- SHW, log2(WIDTH), shift-amount width (derived, not overridable).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  operation request.
- in_ready_o  output  1  block can accept a request this cycle.
- data1_i  input  WIDTH  operand A, signed.
- data2_i  input  WIDTH  operand B, signed.
- ALUCtrl_i  input  3  operation select.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- data_o  output  WIDTH  result, signed.
- Zero_o  output  1  high when data_o equals 0; qualified by out_valid_o.

Behaviour:
- Reset (rst_i low, async): state=IDLE, out_valid_o=0, data_o=0, Zero_o=0, internal accumulator and counter cleared.
  - Reset asserted mid-MUL aborts the operation; no result is produced.
- Op encoding:
  - 000 AND
  - 001 XOR
  - 011 SLL by data2_i[SHW-1:0]
  - 010 ADD
  - 110 SUB
  - 111 MUL (low WIDTH bits of the product)
  - 101 ADD (immediate form)
  - 100 SRA by data2_i[SHW-1:0], sign-filled
- Arithmetic rules: ADD/SUB wrap modulo 2^WIDTH with no overflow flag; shift amounts use only the low SHW bits.
- Handshake:
  - A request is accepted when in_valid_i && in_ready_o at a rising edge.
  - A result is consumed when out_valid_o && out_ready_i.
  - in_ready_o = (state==IDLE) || (state==DONE && out_ready_i). This is combinational, so back-to-back throughput is 1 op per cycle for non-MUL ops.
- States:
  - IDLE: on accept of a non-MUL op, register the result into data_o and Zero_o, then go to DONE. On accept of MUL, latch A into the multiplicand, B into the multiplier, clear the accumulator and counter, then go to MUL. With no accept, stay in IDLE.
  - MUL: each cycle add the multiplicand × (low MUL_STEP bits of the multiplier) into the accumulator; shift the multiplicand left by MUL_STEP and the multiplier right by MUL_STEP; increment the counter. After WIDTH/MUL_STEP cycles, load data_o and Zero_o from the accumulator and go to DONE. in_ready_o is 0 throughout.
  - DONE: out_valid_o=1. If out_ready_i=0, hold data_o and Zero_o stable and stay in DONE; in_ready_o is 0. If out_ready_i=1, the result is consumed this edge. If in_valid_i is also 1, the new op is accepted in the same edge: a non-MUL op stays in DONE with the new result, a MUL op goes to MUL. Otherwise go to IDLE with out_valid_o=0.
- Latency:
  - Non-MUL: accepted at edge N, out_valid_o high after edge N.
  - MUL: out_valid_o high after edge N+WIDTH/MUL_STEP.
- Operand capture: inputs are sampled only at accept. Changes to data1_i, data2_i or ALUCtrl_i afterwards do not affect the in-flight op.
- Signed MUL: the low WIDTH bits are identical for signed and unsigned products, so no sign correction is applied.
- Outputs are registered. data_o and Zero_o change only on accept (non-MUL), on MUL completion, or on reset.

Test Plan:
- Reset: hold rst_i low for 3 cycles with in_valid_i=1 → out_valid_o=0, data_o=0, in_ready_o=1 after release.
- Single-cycle ops, WIDTH=32, out_ready_i=1:
  - SUB 5−5 → data_o=0, Zero_o=1, one cycle after accept.
  - SRA 0x80000000 by 0x24 → 0xF8000000 (shamt 4).
  - SLL 1 by 31 → 0x80000000.
- MUL with MUL_STEP=1: −3×7 → data_o=0xFFFFFFEB exactly 32 cycles after accept, with in_ready_o=0 during MUL. Repeat with MUL_STEP=4 → 8 cycles, same result.
- Backpressure: issue ADD 2+3 with out_ready_i=0 for 5 cycles → data_o=5 held stable and in_ready_o=0. Raising out_ready_i together with a queued XOR 0xF0^0xFF → data_o=0x0F on the next cycle, with no bubble.
- Back-to-back stream: 8 consecutive ADDs with in_valid_i=out_ready_i=1 → 8 results on 8 consecutive cycles, in order.
- Reset mid-MUL: drop rst_i at cycle 10 of a MUL → outputs cleared immediately, state IDLE, no spurious out_valid_o after release.

Source files
------------

// File: rtl/pipelined_alu.sv
// Registered EX-stage ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arithmetic ops plus an iterative shift-add multiply.
module pipelined_alu #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       ALUCtrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state, state_next;

    logic             accept;
    logic             is_mul;
    logic             mul_last;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;

    // A consumer draining DONE frees the slot in the same cycle, so a new op can follow with no bubble.
    assign in_ready_o  = (state == IDLE) || ((state == DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign is_mul      = (ALUCtrl_i == 3'b111);
    assign mul_last    = (cnt == CNT_W'(STEPS - 1));
    assign out_valid_o = (state == DONE);
    assign shamt       = data2_i[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (ALUCtrl_i)
            3'b000:         alu_result = data1_i & data2_i;
            3'b001:         alu_result = data1_i ^ data2_i;
            3'b011:         alu_result = data1_i << shamt;
            3'b010, 3'b101: alu_result = data1_i + data2_i;
            3'b110:         alu_result = data1_i - data2_i;
            3'b100:         alu_result = WIDTH'($signed(data1_i) >>> shamt);
            default:        alu_result = '0;
        endcase
    end

    // Low WIDTH bits of a product are sign-agnostic, so an unsigned shift-add suffices.
    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) begin
                partial = partial + (mcand << j);
            end
        end
        acc_next = acc + partial;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_mul ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = is_mul ? MUL : DONE;
                end else if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= '0;
            Zero_o <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= data1_i;
                mplier <= data2_i;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                data_o <= alu_result;
                Zero_o <= (alu_result == '0);
            end
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << MUL_STEP;
            mplier <= mplier >> MUL_STEP;
            cnt    <= cnt + CNT_W'(1);
            if (mul_last) begin
                data_o <= acc_next;
                Zero_o <= (acc_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: two instances (MUL_STEP 1 and 4)
// share stimulus and are compared against an arithmetic reference model.
module tb_pipelined_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        out_ready;

    logic        rdy1, ov1, z1;
    logic [31:0] dat1;
    logic        rdy4, ov4, z4;
    logic [31:0] dat4;

    int checks   = 0;
    int failures = 0;

    pipelined_alu #(.WIDTH(32), .MUL_STEP(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .data1_i(d1), .data2_i(d2), .ALUCtrl_i(ctrl), .out_valid_o(ov1),
        .out_ready_i(out_ready), .data_o(dat1), .Zero_o(z1)
    );

    pipelined_alu #(.WIDTH(32), .MUL_STEP(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy4),
        .data1_i(d1), .data2_i(d2), .ALUCtrl_i(ctrl), .out_valid_o(ov4),
        .out_ready_i(out_ready), .data_o(dat4), .Zero_o(z4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        logic [31:0] r;
        int sh;
        sh = int'(b[4:0]);
        case (op)
            3'b000:         r = a & b;
            3'b001:         r = a ^ b;
            3'b011:         r = a * (32'd1 << sh);
            3'b010, 3'b101: r = a + b;
            3'b110:         r = a + (~b + 32'd1);
            3'b111: begin
                prod = {32'd0, a} * {32'd0, b};
                r = prod[31:0];
            end
            default: begin
                r = a;
                for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
            end
        endcase
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; ctrl = 3'b010; d1 = 32'd1; d2 = 32'd2; out_ready = 1'b1;
        repeat (3) step;
        checks++; if (ov1 !== 1'b0 || ov4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b/%b want 0", ov1, ov4); end
        checks++; if (dat1 !== 32'd0 || dat4 !== 32'd0) begin failures++; $display("[TB] FAIL reset_data got %h/%h want 0", dat1, dat4); end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (rdy1 !== 1'b1 || rdy4 !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got %b/%b want 1", rdy1, rdy4); end
        checks++; if (ov1 !== 1'b0 || z1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_after got valid=%b zero=%b want 0/0", ov1, z1); end
    endtask

    task automatic test_single_cycle;
        logic [2:0]  ops [8];
        logic [31:0] as  [8];
        logic [31:0] bs  [8];
        logic [31:0] exp [8];
        ops = '{3'b110, 3'b100, 3'b011, 3'b000, 3'b001, 3'b101, 3'b010, 3'b110};
        as  = '{32'd5, 32'h8000_0000, 32'd1, 32'hF0F0_1234, 32'hAAAA_5555, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        bs  = '{32'd5, 32'h24, 32'd31, 32'h0FF0_FFFF, 32'hFFFF_0000, 32'd1, 32'd1, 32'd1};
        exp = '{32'd0, 32'hF800_0000, 32'h8000_0000, 32'h00F0_1234, 32'h5555_5555, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; ctrl = ops[i]; d1 = as[i]; d2 = bs[i];
            step;
            in_valid = 1'b0; d1 = $urandom; d2 = $urandom;
            checks++;
            if (ov1 !== 1'b1 || dat1 !== exp[i] || z1 !== (exp[i] == 32'd0)) begin
                failures++; $display("[TB] FAIL single_op%0d dut1 got v=%b d=%h z=%b want d=%h", i, ov1, dat1, z1, exp[i]);
            end
            checks++;
            if (ov4 !== 1'b1 || dat4 !== exp[i] || z4 !== (exp[i] == 32'd0)) begin
                failures++; $display("[TB] FAIL single_op%0d dut4 got v=%b d=%h z=%b want d=%h", i, ov4, dat4, z4, exp[i]);
            end
            step;
        end
    endtask

    task automatic test_mul;
        int lat1 = 0;
        int lat4 = 0;
        int bad_ready = 0;
        out_ready = 1'b0; in_valid = 1'b1; ctrl = 3'b111; d1 = -32'sd3; d2 = 32'd7;
        step;
        in_valid = 1'b0; d1 = $urandom; d2 = $urandom; ctrl = 3'($urandom);
        for (int k = 1; k <= 40; k++) begin
            step;
            if (rdy1 !== 1'b0) bad_ready++;
            if (lat1 == 0 && ov1 === 1'b1) lat1 = k;
            if (lat4 == 0 && ov4 === 1'b1) lat4 = k;
        end
        checks++; if (lat1 != 32) begin failures++; $display("[TB] FAIL mul_latency1 got %0d want 32", lat1); end
        checks++; if (lat4 != 8) begin failures++; $display("[TB] FAIL mul_latency4 got %0d want 8", lat4); end
        checks++; if (dat1 !== 32'hFFFF_FFEB || z1 !== 1'b0) begin failures++; $display("[TB] FAIL mul_result1 got %h z=%b want ffffffeb", dat1, z1); end
        checks++; if (dat4 !== 32'hFFFF_FFEB || z4 !== 1'b0) begin failures++; $display("[TB] FAIL mul_result4 got %h z=%b want ffffffeb", dat4, z4); end
        checks++; if (bad_ready != 0) begin failures++; $display("[TB] FAIL mul_ready got %0d cycles ready want 0", bad_ready); end
        out_ready = 1'b1;
        step;
        checks++; if (ov1 !== 1'b0 || ov4 !== 1'b0) begin failures++; $display("[TB] FAIL mul_drain got %b/%b want 0", ov1, ov4); end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        out_ready = 1'b0; in_valid = 1'b1; ctrl = 3'b010; d1 = 32'd2; d2 = 32'd3;
        step;
        in_valid = 1'b0;
        repeat (5) begin
            d1 = $urandom; d2 = $urandom; ctrl = 3'($urandom);
            step;
            if (ov1 !== 1'b1 || dat1 !== 32'd5 || rdy1 !== 1'b0) bad++;
            if (ov4 !== 1'b1 || dat4 !== 32'd5 || rdy4 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL hold_stable got %0d bad samples want 0", bad); end
        out_ready = 1'b1; in_valid = 1'b1; ctrl = 3'b001; d1 = 32'hF0; d2 = 32'hFF;
        #1;
        checks++; if (rdy1 !== 1'b1 || rdy4 !== 1'b1) begin failures++; $display("[TB] FAIL release_ready got %b/%b want 1", rdy1, rdy4); end
        step;
        in_valid = 1'b0;
        checks++; if (ov1 !== 1'b1 || dat1 !== 32'h0F || ov4 !== 1'b1 || dat4 !== 32'h0F) begin
            failures++; $display("[TB] FAIL queued_xor got %h/%h want 0000000f", dat1, dat4);
        end
        step;
    endtask

    task automatic test_back_to_back;
        logic [31:0] expq [$];
        logic [31:0] e;
        int bad_ready = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; ctrl = (i % 2 == 1) ? 3'b101 : 3'b010; d1 = $urandom; d2 = $urandom;
            expq.push_back(model(ctrl, d1, d2));
            #1;
            if (rdy1 !== 1'b1) bad_ready++;
            step;
            e = expq.pop_front();
            checks++;
            if (ov1 !== 1'b1 || dat1 !== e || ov4 !== 1'b1 || dat4 !== e) begin
                failures++; $display("[TB] FAIL stream%0d got v=%b d=%h/%h want %h", i, ov1, dat1, dat4, e);
            end
        end
        in_valid = 1'b0;
        checks++; if (bad_ready != 0) begin failures++; $display("[TB] FAIL stream_ready got %0d stalls want 0", bad_ready); end
        step;
        checks++; if (ov1 !== 1'b0) begin failures++; $display("[TB] FAIL stream_end got valid=%b want 0", ov1); end
    endtask

    task automatic test_random;
        logic [31:0] e;
        int cyc;
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'b0; in_valid = 1'b1; ctrl = 3'($urandom_range(0, 7));
            d1 = $urandom; d2 = ($urandom_range(0, 3) == 0) ? d1 : $urandom;
            e = model(ctrl, d1, d2);
            step;
            in_valid = 1'b0; d1 = $urandom; d2 = $urandom; ctrl = 3'($urandom);
            cyc = 0;
            while (!(ov1 === 1'b1 && ov4 === 1'b1) && cyc < 50) begin
                step;
                cyc++;
            end
            checks++;
            if (cyc >= 50) begin
                failures++; $display("[TB] FAIL rand%0d timeout got valid=%b/%b want 1/1", i, ov1, ov4);
            end else if (dat1 !== e || z1 !== (e == 32'd0) || dat4 !== e || z4 !== (e == 32'd0)) begin
                failures++; $display("[TB] FAIL rand%0d got %h z=%b / %h z=%b want %h", i, dat1, z1, dat4, z4, e);
            end
            out_ready = 1'b1;
            step;
        end
    endtask

    task automatic test_reset_mid_mul;
        int bad = 0;
        out_ready = 1'b1; in_valid = 1'b1; ctrl = 3'b111; d1 = 32'h1234_5677; d2 = 32'h0000_0F0F;
        step;
        in_valid = 1'b0;
        repeat (9) step;
        rst_n = 1'b0;
        #1;
        checks++; if (ov1 !== 1'b0 || dat1 !== 32'd0 || z1 !== 1'b0) begin
            failures++; $display("[TB] FAIL midmul_clear got v=%b d=%h z=%b want 0/0/0", ov1, dat1, z1);
        end
        checks++; if (rdy1 !== 1'b1 || dat4 !== 32'd0) begin
            failures++; $display("[TB] FAIL midmul_idle got ready=%b d4=%h want 1/0", rdy1, dat4);
        end
        step;
        rst_n = 1'b1;
        repeat (40) begin
            step;
            if (ov1 !== 1'b0 || ov4 !== 1'b0) bad++;
        end
        checks++; if (bad != 0 || dat1 !== 32'd0) begin
            failures++; $display("[TB] FAIL midmul_spurious got %0d valid cycles d=%h want 0", bad, dat1);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; ctrl = 3'b000; d1 = '0; d2 = '0; out_ready = 1'b0;
        test_reset;
        test_single_cycle;
        test_mul;
        test_backpressure;
        test_back_to_back;
        test_random;
        test_reset_mid_mul;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
